// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchroniser plus stability-counter debouncer with rise/fall strobes
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_raw,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("debounce_sync: SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_cycles
        $error("debounce_sync: DEBOUNCE_CYCLES must be 2..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   din_s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;

    assign din_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_raw};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // Any bounce back to the held level discards the partial count entirely.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (din_s) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_HI: begin
                if (!din_s) begin
                    state_d = STABLE_LO;
                end else if (cnt_q == TERM_CNT) begin
                    state_d = STABLE_HI;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!din_s) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_LO: begin
                if (din_s) begin
                    state_d = STABLE_HI;
                end else if (cnt_q == TERM_CNT) begin
                    state_d = STABLE_LO;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = STABLE_LO;
        endcase
        busy_d = (state_d == PEND_HI) || (state_d == PEND_LO);
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - scoreboard bench for debounce_sync (small and default parameters)
module tb_debounce_sync;

    localparam int SS = 2;
    localparam int DC = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n   = 1'b0;
    logic din_raw = 1'b0;
    logic dout, rise, fall, busy;

    logic rst2_n = 1'b0;
    logic din2   = 1'b0;
    logic dout2, rise2, fall2, busy2;

    int checks   = 0;
    int failures = 0;

    debounce_sync #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_raw (din_raw),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    debounce_sync u_dut_def (
        .clk     (clk),
        .rst_n   (rst2_n),
        .din_raw (din2),
        .dout    (dout2),
        .rise    (rise2),
        .fall    (fall2),
        .busy    (busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic d;
        logic r;
        logic f;
        logic b;
    } exp_t;

    exp_t          sb_q[$];
    bit [SS-1:0]   m_sync  = '0;
    bit            m_level = 1'b0;
    int            m_run   = 0;

    // Reference: count consecutive synchronised samples differing from the held level.
    task automatic step(input bit rst, input bit din, input string tag);
        exp_t e;
        bit   ds;
        @(negedge clk);
        rst_n   = rst;
        din_raw = din;
        ds = m_sync[SS-1];
        e  = '0;
        if (!rst) begin
            m_sync  = '0;
            m_level = 1'b0;
            m_run   = 0;
        end else begin
            if (ds != m_level) begin
                m_run++;
                if (m_run == DC) begin
                    m_level = ds;
                    m_run   = 0;
                    e.r     = ds;
                    e.f     = !ds;
                end
            end else begin
                m_run = 0;
            end
            m_sync = {m_sync[SS-2:0], din};
        end
        e.d = m_level;
        e.b = (m_run != 0);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".dout"}, 32'(dout), 32'(e.d));
            check({tag, ".rise"}, 32'(rise), 32'(e.r));
            check({tag, ".fall"}, 32'(fall), 32'(e.f));
            check({tag, ".busy"}, 32'(busy), 32'(e.b));
        end
    endtask

    int  rise_edge;
    int  n_rise;
    int  n_fall;
    int  n;
    bit  seen;
    bit  pat [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        // 1: reset with din toggling
        step(0, 1, "rst0");
        step(0, 0, "rst1");
        step(0, 1, "rst2");
        step(1, 0, "rst_rel");

        // 2: clean rise, rise edge must be SS+DC
        rise_edge = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, "rise");
            if (rise) rise_edge = i;
        end
        check("rise_edge", 32'(rise_edge), 32'd6);
        for (int i = 0; i < 8; i++) step(1, 0, "settle_lo");

        // 3: glitch of DC-1 rejected, DC accepted
        n_rise = 0;
        for (int i = 0; i < 3; i++) begin step(1, 1, "glitch"); n_rise += int'(rise); end
        for (int i = 0; i < 8; i++) begin step(1, 0, "glitch"); n_rise += int'(rise); end
        check("glitch_rises", 32'(n_rise), 32'd0);
        for (int i = 0; i < 4; i++) begin step(1, 1, "exact"); n_rise += int'(rise); end
        for (int i = 0; i < 8; i++) step(1, 1, "settle_hi");
        n_rise += 0;
        check("exact_dout", 32'(dout), 32'd1);

        // 4: bounce inside PEND_LO
        n_fall = 0;
        foreach (pat[i]) begin step(1, pat[i], "bounce"); n_fall += int'(fall); end
        for (int i = 0; i < 4; i++) begin step(1, 0, "bounce_tail"); n_fall += int'(fall); end
        check("bounce_falls", 32'(n_fall), 32'd1);
        check("bounce_dout", 32'(dout), 32'd0);

        // 5: reset in PEND_HI, then full latency again
        for (int i = 0; i < 4; i++) step(1, 1, "pend");
        check("pend_busy", 32'(busy), 32'd1);
        step(0, 1, "mid_rst");
        rise_edge = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1, 1, "post_rst");
            if (rise) rise_edge = i;
        end
        check("post_rst_rise_edge", 32'(rise_edge), 32'd6);

        // 6: default parameters
        @(negedge clk); rst2_n = 1'b0; din2 = 1'b0;
        @(negedge clk); rst2_n = 1'b1;
        @(negedge clk); din2 = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 1100) begin
            @(posedge clk); #1;
            n++;
            if (dout2) seen = 1;
        end
        check("def_rise_edge", 32'(n), 32'd1002);
        check("def_rise_pulse", 32'(rise2), 32'd1);
        @(negedge clk); din2 = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 1100) begin
            @(posedge clk); #1;
            n++;
            if (!dout2) seen = 1;
        end
        check("def_fall_edge", 32'(n), 32'd1002);
        n_rise = 0;
        @(negedge clk); din2 = 1'b1;
        for (int i = 0; i < 999; i++) begin @(posedge clk); #1; n_rise += int'(rise2 | dout2); end
        @(negedge clk); din2 = 1'b0;
        for (int i = 0; i < 1010; i++) begin @(posedge clk); #1; n_rise += int'(rise2 | dout2); end
        check("def_999_no_change", 32'(n_rise), 32'd0);
        check("def_idle_busy", 32'(busy2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Front-end conditioning stage that sits directly upstream of the rising-edge D flip-flop stage and drives its d input.
- Takes a raw, asynchronous, bouncy single-bit input such as a push-button or switch.
- Synchronises it into the clk domain and debounces it with a stability counter.
- Produces a clean level plus single-cycle rise/fall strobes for downstream sequential logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on din_raw; legal range 2..4.
- DEBOUNCE_CYCLES, 1000, consecutive synchronised cycles at the new level required before dout changes; legal range 2..2^CNT_W-1.
- CNT_W, 16, stability counter width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- din_raw  input  1  raw asynchronous input; no timing relationship to clk.
- dout  output  1  debounced, synchronised level (registered).
- rise  output  1  one-cycle pulse coincident with dout going 0->1 (registered).
- fall  output  1  one-cycle pulse coincident with dout going 1->0 (registered).
- busy  output  1  high while a candidate level change is being qualified (state PEND_HI or PEND_LO).

Behaviour:

Reset:
- One clock, single edge; rst_n is sampled only at the rising edge of clk (synchronous, active-low).
- While rst_n=0 at an edge: all synchroniser flops 0, state STABLE_LO, cnt 0, dout 0, rise 0, fall 0, busy 0.
- Reset has priority over every other event, including mid-qualification.

Synchroniser:
- SYNC_STAGES flop chain; din_s is the last stage.
- No logic between the stages.
- din_raw is used nowhere else.

FSM (4 states; cnt is CNT_W bits, unsigned):
- STABLE_LO: dout=0.
  - din_s=1 -> PEND_HI, cnt<=1.
  - else stay, cnt<=0.
- PEND_HI:
  - din_s=0 -> STABLE_LO, cnt<=0 (glitch rejected, no pulse).
  - din_s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, dout<=1, rise<=1, cnt<=0.
  - else cnt<=cnt+1.
- STABLE_HI: dout=1.
  - din_s=0 -> PEND_LO, cnt<=1.
  - else stay.
- PEND_LO: mirror of PEND_HI.
  - din_s=1 -> STABLE_HI (reject).
  - Terminal count -> STABLE_LO, dout<=0, fall<=1.

Outputs and timing:
- rise and fall default to 0 every cycle; each is high for exactly one cycle per transition.
- rise and fall are never simultaneously high.
- busy is a registered decode of the next state: high exactly in the cycles the FSM is in PEND_HI or PEND_LO.
- Latency: number rising edges from the first edge that samples din_raw at the new level as edge 1, with din_raw held. dout, rise and fall update at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Glitch filter: a level held for fewer than DEBOUNCE_CYCLES synchronised cycles never changes dout. Holding for exactly DEBOUNCE_CYCLES does change it.
- Counter never wraps: it is bounded by the terminal compare, so DEBOUNCE_CYCLES must be ≤ 2^CNT_W-1 (elaboration-time check).
- Bounce inside PEND restarts qualification from the stable state. There is no partial-credit accumulation.

Reset mid-operation:
- Reset in PEND_* returns to STABLE_LO with dout 0.
- Reset in STABLE_HI drops dout to 0 with no fall pulse.
- After release with din_raw still 1, the full latency applies again and a rise pulse is emitted.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=4 unless noted):
1. Reset: rst_n=0 for 3 edges with din_raw toggling -> dout=0, rise=0, fall=0, busy=0 on every cycle during reset and the first cycle after.
2. Clean rise: din_raw 0->1 and held -> dout=1 and rise=1 exactly at edge 6. rise=0 at edge 7. busy=1 on the cycles after edges 3-5 only.
3. Glitch rejection: din_raw high for 3 edges then low -> dout stays 0, no rise. A subsequent high of 4 edges -> dout=1 with one rise pulse.
4. Bounce during PEND_LO: from dout=1, din_raw pattern 0,0,1,0,0,0,0 -> no fall until the final run of four 0s completes. Then exactly one fall pulse and dout=0.
5. Reset mid-qualification: assert rst_n=0 while busy=1 in PEND_HI, release with din_raw=1 -> dout=0 for 5 edges after release, rise at edge 6 after release.
6. Default parameters (2/1000/16): held high -> dout rises at edge 1002. A 999-cycle pulse produces no change.
